com_bus_arbiter: RTL and testbench

//  Arbitrates the shared common bus among the per-core cache wrappers of the 4-core MESI system.

---
 rtl/com_bus_arbiter_pkg.sv | 22 ++
 rtl/com_bus_arbiter_if.sv | 30 +++
 rtl/com_bus_arbiter_rr_select.sv | 29 ++
 rtl/com_bus_arbiter.sv | 105 ++++++++++
 tb/tb_com_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/com_bus_arbiter_pkg.sv
// Shared definitions for the common-bus arbiter: core count, index width, proc FSM states and mask helpers.
package com_bus_arbiter_pkg;

  localparam int NUM_CORES = 4;
  localparam int IDX_W     = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_GRANT   = 2'd1,
    P_RELEASE = 2'd2
  } p_state_e;

  function automatic logic [NUM_CORES-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
    return NUM_CORES'(1) << idx;
  endfunction

  // Isolates the lowest set bit (v & -v).
  function automatic logic [NUM_CORES-1:0] lowest_onehot(input logic [NUM_CORES-1:0] v);
    return v & (~v + NUM_CORES'(1));
  endfunction

endpackage

// File: rtl/com_bus_arbiter_if.sv
// Common-bus arbitration signals between the arbiter (master) and the cache wrappers (slave).
interface com_bus_arbiter_if;
  import com_bus_arbiter_pkg::*;

  // Level handshake: a core holds its request until its transaction is done; a grant stays
  // asserted while the request stays high, and the grant drops on the edge after the request drops.
  logic [NUM_CORES-1:0] Com_Bus_Req_proc;
  logic [NUM_CORES-1:0] Com_Bus_Req_snoop;
  logic [NUM_CORES-1:0] Invalidation_done;
  logic [NUM_CORES-1:0] Shared_local;
  logic [NUM_CORES-1:0] Com_Bus_Gnt_proc;
  logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop;
  logic                 All_Invalidation_done;
  logic                 Shared;
  logic [IDX_W-1:0]     Bus_owner;
  logic                 Bus_timeout;

  modport master (
    input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidation_done, Shared_local,
    output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
           Bus_owner, Bus_timeout
  );

  modport slave (
    output Com_Bus_Req_proc, Com_Bus_Req_snoop, Invalidation_done, Shared_local,
    input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, All_Invalidation_done, Shared,
           Bus_owner, Bus_timeout
  );

endinterface

// File: rtl/com_bus_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr, circular.
module com_bus_arbiter_rr_select
  import com_bus_arbiter_pkg::*;
(
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = (int'(ptr) + k) % NUM_CORES;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter for the 4-core MESI system: round-robin proc grants, snoop data grants, ack/shared merge.
// Optional forced grant revoke after TIMEOUT_CYC cycles when COM_BUS_TIMEOUT_EN is defined.
module com_bus_arbiter
  import com_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  com_bus_arbiter_if.master bus,
  output p_state_e          dbg_state
);

  p_state_e             state, state_next;
  logic [NUM_CORES-1:0] gnt_proc, gnt_snoop, gnt_snoop_next;
  logic [NUM_CORES-1:0] owner_mask, snoop_cand, sel_gnt;
  logic [IDX_W-1:0]     owner, rr_ptr, sel_idx;
  logic                 sel_any, owner_drop, timeout_hit, stay_grant;
  logic                 aid, aid_next, shared, bus_timeout;

  com_bus_arbiter_rr_select u_rr_select (
    .req (bus.Com_Bus_Req_proc),
    .ptr (rr_ptr),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign owner_mask = idx_to_mask(owner);
  assign owner_drop = !bus.Com_Bus_Req_proc[owner];

`ifdef COM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state != P_GRANT) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  // A voluntary release on the same edge takes priority over a forced revoke.
  assign timeout_hit = (state == P_GRANT) && !owner_drop && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  // No revoke path; the parameter only shapes the counter when that path exists.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= P_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      P_IDLE:    if (sel_any) state_next = P_GRANT;
      P_GRANT:   if (owner_drop || timeout_hit) state_next = P_RELEASE;
      P_RELEASE: state_next = P_IDLE;
      default:   state_next = P_IDLE;
    endcase
  end

  always_comb begin
    stay_grant     = (state == P_GRANT) && (state_next == P_GRANT);
    snoop_cand     = bus.Com_Bus_Req_snoop & ~owner_mask;
    gnt_snoop_next = '0;
    if (stay_grant) begin
      if (|(gnt_snoop & snoop_cand)) gnt_snoop_next = gnt_snoop;
      else                           gnt_snoop_next = lowest_onehot(snoop_cand);
    end
    aid_next = stay_grant && ((bus.Invalidation_done & ~owner_mask) == ~owner_mask);
    shared   = (state == P_GRANT) && |(bus.Shared_local & ~owner_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_proc    <= '0;
      gnt_snoop   <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      aid         <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      gnt_snoop   <= gnt_snoop_next;
      aid         <= aid_next;
      bus_timeout <= timeout_hit;
      if (state == P_IDLE && sel_any) begin
        gnt_proc <= sel_gnt;
        owner    <= sel_idx;
      end else if (state == P_GRANT && state_next == P_RELEASE) begin
        gnt_proc <= '0;
        rr_ptr   <= (owner == IDX_W'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  assign bus.Com_Bus_Gnt_proc      = gnt_proc;
  assign bus.Com_Bus_Gnt_snoop     = gnt_snoop;
  assign bus.All_Invalidation_done = aid;
  assign bus.Shared                = shared;
  assign bus.Bus_owner             = owner;
  assign bus.Bus_timeout           = bus_timeout;
  assign dbg_state                 = state;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed scenarios with literal expectations, then random traffic vs a bus-level model.
module tb_com_bus_arbiter;
  import com_bus_arbiter_pkg::*;

  localparam int N      = NUM_CORES;
  localparam int TO_CYC = 8;
  localparam int EW     = 2 * N + 2;
`ifdef COM_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic     clk   = 1'b0;
  logic     rst_n = 1'b0;
  p_state_e dbg_state;

  com_bus_arbiter_if bus_if ();

  com_bus_arbiter #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return (i < 0) ? '0 : (one << i);
  endfunction

  // ---------------- bus-level model ----------------
  // Owner -1 means the bus is free; dead marks the turnaround cycle after a release.
  int m_owner = -1, m_ptr = 0, m_snoop = -1, m_hold = 0, m_bus_owner = 0;
  bit m_dead = 0, m_aid = 0, m_timeout = 0;
  logic [EW-1:0] exp_q[$];

  always @(posedge clk) begin
    logic [N-1:0] rq, sq, iv;
    bit drop, to, all_ack;
    rq = bus_if.Com_Bus_Req_proc;
    sq = bus_if.Com_Bus_Req_snoop;
    iv = bus_if.Invalidation_done;
    m_timeout = 0;
    m_aid     = 0;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_snoop = -1; m_hold = 0; m_bus_owner = 0; m_dead = 0;
    end else if (m_owner >= 0) begin
      drop = !rq[m_owner];
      to   = TO_EN && !drop && (m_hold == TO_CYC - 1);
      if (drop || to) begin
        m_ptr     = (m_owner + 1) % N;
        m_owner   = -1;
        m_snoop   = -1;
        m_dead    = 1;
        m_timeout = to;
        m_hold    = 0;
      end else begin
        if (!(m_snoop >= 0 && sq[m_snoop])) begin
          m_snoop = -1;
          for (int i = N - 1; i >= 0; i--) if (i != m_owner && sq[i]) m_snoop = i;
        end
        all_ack = 1;
        for (int i = 0; i < N; i++) if (i != m_owner && !iv[i]) all_ack = 0;
        m_aid = all_ack;
        m_hold++;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      if (m_owner >= 0) m_bus_owner = m_owner;
      m_hold = 0;
    end
    exp_q.push_back({oh(m_owner), oh(m_snoop), m_aid, m_timeout});
  end

  function automatic logic exp_shared();
    logic s;
    s = 0;
    for (int i = 0; i < N; i++) if (m_owner >= 0 && i != m_owner && bus_if.Shared_local[i]) s = 1;
    return s;
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt_proc",    {28'd0, bus_if.Com_Bus_Gnt_proc},     {28'd0, e[EW-1 -: N]});
      check("gnt_snoop",   {28'd0, bus_if.Com_Bus_Gnt_snoop},    {28'd0, e[N+1 : 2]});
      check("all_inv_done", {31'd0, bus_if.All_Invalidation_done}, {31'd0, e[1]});
      check("bus_timeout", {31'd0, bus_if.Bus_timeout},          {31'd0, e[0]});
      check("shared",      {31'd0, bus_if.Shared},               {31'd0, exp_shared()});
      if (m_owner >= 0) check("bus_owner", 32'(bus_if.Bus_owner), 32'(m_bus_owner));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] sq,
                       input logic [N-1:0] iv, input logic [N-1:0] sl);
    bus_if.Com_Bus_Req_proc  = rq;
    bus_if.Com_Bus_Req_snoop = sq;
    bus_if.Invalidation_done = iv;
    bus_if.Shared_local      = sl;
  endtask

  initial begin
    drive('0, '0, '0, '0);
    rst_n = 1'b0;
    tick(); tick();
    check("rst_gnt_proc",  32'(bus_if.Com_Bus_Gnt_proc), 32'h0);
    check("rst_gnt_snoop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h0);
    check("rst_aid",       32'(bus_if.All_Invalidation_done), 32'h0);
    check("rst_owner",     32'(bus_if.Bus_owner), 32'h0);
    check("rst_timeout",   32'(bus_if.Bus_timeout), 32'h0);

    // round-robin start and release turnaround
    rst_n = 1'b1;
    drive(4'b0110, '0, '0, '0);
    tick();
    check("t1_first_grant", 32'(bus_if.Com_Bus_Gnt_proc), 32'h2);
    check("t1_owner",       32'(bus_if.Bus_owner), 32'h1);
    drive(4'b0100, '0, '0, '0);
    tick();
    check("t1_release", 32'(bus_if.Com_Bus_Gnt_proc), 32'h0);
    tick();
    check("t1_dead", 32'(bus_if.Com_Bus_Gnt_proc), 32'h0);
    tick();
    check("t1_next_grant", 32'(bus_if.Com_Bus_Gnt_proc), 32'h4);

    // pointer wrap after core3
    drive(4'b1000, '0, '0, '0);
    tick(); tick(); tick();
    check("t2_core3", 32'(bus_if.Com_Bus_Gnt_proc), 32'h8);
    drive(4'b0001, '0, '0, '0);
    tick();
    drive(4'b1001, '0, '0, '0);
    tick(); tick();
    check("t2_wrap_grant", 32'(bus_if.Com_Bus_Gnt_proc), 32'h1);
    check("t2_wrap_owner", 32'(bus_if.Bus_owner), 32'h0);

    // snoop grant skips owner; no snoop grant without a proc grant
    drive(4'b1001, 4'b1011, '0, '0);
    tick();
    check("t3_snoop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h2);
    drive('0, '0, '0, '0);
    tick(); tick();
    drive('0, 4'b1011, '0, '0);
    tick(); tick();
    check("t3_snoop_idle", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h0);

    // ack merge and shared merge around owner core2
    drive(4'b0100, '0, '0, '0);
    tick();
    check("t4_grant", 32'(bus_if.Com_Bus_Gnt_proc), 32'h4);
    drive(4'b0100, '0, 4'b1011, '0);
    tick();
    check("t4_aid_set", 32'(bus_if.All_Invalidation_done), 32'h1);
    drive(4'b0100, '0, 4'b0011, 4'b0100);
    tick();
    check("t4_aid_clr",   32'(bus_if.All_Invalidation_done), 32'h0);
    check("t4_shared_own", 32'(bus_if.Shared), 32'h0);
    drive(4'b0100, '0, '0, 4'b0101);
    #1;
    check("t4_shared_other", 32'(bus_if.Shared), 32'h1);

    // reset in the middle of a transaction with a snoop grant active
    drive(4'b0100, 4'b0001, '0, '0);
    tick();
    check("t6_snoop_before", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h1);
    rst_n = 1'b0;
    tick();
    check("t6_gnt_proc", 32'(bus_if.Com_Bus_Gnt_proc), 32'h0);
    check("t6_gnt_snoop", 32'(bus_if.Com_Bus_Gnt_snoop), 32'h0);
    check("t6_timeout", 32'(bus_if.Bus_timeout), 32'h0);
    rst_n = 1'b1;
    drive(4'b0011, '0, '0, '0);
    tick();
    check("t6_ptr_zero", 32'(bus_if.Com_Bus_Gnt_proc), 32'h1);

`ifdef COM_BUS_TIMEOUT_EN
    begin
      int held;
      bit cleared;
      held    = 1;
      cleared = 0;
      drive(4'b0001, '0, '0, '0);
      for (int c = 0; c < 20 && !cleared; c++) begin
        tick();
        if (bus_if.Com_Bus_Gnt_proc == '0) begin
          cleared = 1;
          check("t5_pulse", 32'(bus_if.Bus_timeout), 32'h1);
        end else held++;
      end
      check("t5_cleared", 32'(cleared), 32'h1);
      check("t5_held", 32'(held), 32'(TO_CYC));
      tick();
      check("t5_pulse_end", 32'(bus_if.Bus_timeout), 32'h0);
    end
`endif

    // random traffic
    drive('0, '0, '0, '0);
    tick(); tick();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) bus_if.Com_Bus_Req_proc[i]  = ~bus_if.Com_Bus_Req_proc[i];
        if ($urandom_range(0, 3) == 0) bus_if.Com_Bus_Req_snoop[i] = ~bus_if.Com_Bus_Req_snoop[i];
        if ($urandom_range(0, 2) == 0) bus_if.Invalidation_done[i] = ~bus_if.Invalidation_done[i];
      end
      bus_if.Shared_local = N'($urandom_range(0, (1 << N) - 1));
      tick();
    end

    rst_n = 1'b1;
    drive('0, '0, '0, '0);
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
